// File: rtl/parking_pkg.sv
// Shared constants, gate FSM encoding and the free-space count helper
// for the parking occupancy tracker.
package parking_pkg;

  localparam int unsigned NUM_SPACES       = 8;
  localparam int unsigned SPACE_W          = 3;
  localparam int unsigned GATE_OPEN_CYCLES = 4;
  localparam int unsigned CNT_W            = $clog2(GATE_OPEN_CYCLES) + 1;
  localparam int unsigned FREE_W           = 4;

  typedef enum logic {
    GATE_IDLE = 1'b0,
    GATE_OPEN = 1'b1
  } gate_state_e;

  // Number of clear bits in an occupancy map
  function automatic logic [FREE_W-1:0] free_spaces(input logic [NUM_SPACES-1:0] map);
    logic [FREE_W-1:0] n;
    n = FREE_W'(NUM_SPACES);
    for (int i = 0; i < NUM_SPACES; i++) begin
      n = n - FREE_W'(map[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/parking_occupancy_tracker_if.sv
// Lane sensor / occupancy bus between the lane side (master) and the tracker (slave).
interface parking_occupancy_tracker_if
  import parking_pkg::*;
;
  logic                  entry;
  logic [SPACE_W-1:0]    park_number;
  logic                  exit;
  logic [SPACE_W-1:0]    exit_number;
  logic [NUM_SPACES-1:0] parking_capacity;
  logic [FREE_W-1:0]     free_count;
  logic                  full;
  logic                  entry_gate_open;
  logic                  exit_gate_open;
  logic                  entry_denied;
  logic                  exit_error;

  modport master (
    output entry, park_number, exit, exit_number,
    input  parking_capacity, free_count, full,
           entry_gate_open, exit_gate_open, entry_denied, exit_error
  );

  modport slave (
    input  entry, park_number, exit, exit_number,
    output parking_capacity, free_count, full,
           entry_gate_open, exit_gate_open, entry_denied, exit_error
  );

endinterface

// File: rtl/gate_controller.sv
// One lane barrier: sensor rising-edge detect, IDLE/OPEN FSM and open-time counter.
// accept_c is combinational so the owner can update occupancy on the same edge.
module gate_controller
  import parking_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic sensor,
  input  logic legal,
  output logic accept_c,
  output logic reject,
  output logic gate_open
);

  gate_state_e      state;
  gate_state_e      state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             sensor_q;
  logic             rise_c;
  logic             reject_d;
  logic             gate_open_d;

  // State, counter, edge-detect delay and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= GATE_IDLE;
      cnt       <= '0;
      sensor_q  <= 1'b0;
      reject    <= 1'b0;
      gate_open <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      sensor_q  <= sensor;
      reject    <= reject_d;
      gate_open <= gate_open_d;
    end
  end

  // Next state: edges are only acted on while idle
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rise_c  = sensor & ~sensor_q;
    case (state)
      GATE_IDLE: begin
        if (rise_c && legal) begin
          state_d = GATE_OPEN;
          cnt_d   = CNT_W'(GATE_OPEN_CYCLES - 1);
        end
      end
      GATE_OPEN: begin
        if (cnt == '0) state_d = GATE_IDLE;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      default: state_d = GATE_IDLE;
    endcase
  end

  // Outputs: accept/reject decided on the edge, gate follows the next state
  always_comb begin
    accept_c    = 1'b0;
    reject_d    = 1'b0;
    gate_open_d = (state_d == GATE_OPEN);
    if (state == GATE_IDLE && rise_c) begin
      accept_c = legal;
      reject_d = ~legal;
    end
  end

endmodule

// File: rtl/parking_occupancy_tracker.sv
// Owner of the lot occupancy bitmap: legality checks for both lanes, merged
// set/clear update, and registered free_count / full.
module parking_occupancy_tracker
  import parking_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  parking_occupancy_tracker_if.slave  bus
);

  logic [NUM_SPACES-1:0] cap_q;
  logic [NUM_SPACES-1:0] cap_d;
  logic [NUM_SPACES-1:0] set_c;
  logic [NUM_SPACES-1:0] clr_c;
  logic [FREE_W-1:0]     free_q;
  logic                  full_q;
  logic                  entry_legal_c;
  logic                  exit_legal_c;
  logic                  entry_accept_c;
  logic                  exit_accept_c;
  logic                  entry_denied;
  logic                  exit_error;
  logic                  entry_gate_open;
  logic                  exit_gate_open;

  // Both lanes judge against the pre-update map
  assign entry_legal_c = ~full_q & ~cap_q[bus.park_number];
  assign exit_legal_c  = cap_q[bus.exit_number];

  gate_controller u_entry_gate (
    .clk       (clk),
    .reset     (reset),
    .sensor    (bus.entry),
    .legal     (entry_legal_c),
    .accept_c  (entry_accept_c),
    .reject    (entry_denied),
    .gate_open (entry_gate_open)
  );

  gate_controller u_exit_gate (
    .clk       (clk),
    .reset     (reset),
    .sensor    (bus.exit),
    .legal     (exit_legal_c),
    .accept_c  (exit_accept_c),
    .reject    (exit_error),
    .gate_open (exit_gate_open)
  );

  // Same-index conflicts resolve themselves: only one side can be legal
  always_comb begin
    set_c = '0;
    clr_c = '0;
    set_c[bus.park_number] = entry_accept_c;
    clr_c[bus.exit_number] = exit_accept_c;
    cap_d = (cap_q | set_c) & ~clr_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q  <= '0;
      free_q <= FREE_W'(NUM_SPACES);
      full_q <= 1'b0;
    end else begin
      cap_q  <= cap_d;
      free_q <= free_spaces(cap_d);
      full_q <= &cap_d;
    end
  end

  assign bus.parking_capacity = cap_q;
  assign bus.free_count       = free_q;
  assign bus.full             = full_q;
  assign bus.entry_gate_open  = entry_gate_open;
  assign bus.exit_gate_open   = exit_gate_open;
  assign bus.entry_denied     = entry_denied;
  assign bus.exit_error       = exit_error;

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// Bench for parking_occupancy_tracker: table of lane events with hand-computed
// end states, plus a per-cycle reference model feeding an expectation queue.
module tb_parking_occupancy_tracker;

  logic clk = 1'b0;
  logic reset;

  parking_occupancy_tracker_if bif ();

  parking_occupancy_tracker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] cap;
    logic [3:0] free;
    logic       full;
    logic       eg;
    logic       xg;
    logic       den;
    logic       err;
  } obs_t;

  typedef struct {
    logic       e;
    logic [2:0] pn;
    logic       x;
    logic [2:0] xn;
    logic [7:0] cap;
    int         eg;
    int         xg;
    int         den;
    int         err;
  } row_t;

  int   n_checks = 0;
  int   n_errors = 0;
  obs_t exp_q[$];
  row_t rows[$];

  // Reference model state
  logic [7:0] m_cap = '0;
  logic       m_eq = 1'b0, m_xq = 1'b0;
  int         m_el = 0, m_xl = 0;
  logic       m_den = 1'b0, m_err = 1'b0;

  // Observed activity over a row / sequence
  int eg_cnt, xg_cnt, den_cnt, err_cnt;

  function automatic obs_t observe();
    obs_t o;
    o.cap  = bif.parking_capacity;
    o.free = bif.free_count;
    o.full = bif.full;
    o.eg   = bif.entry_gate_open;
    o.xg   = bif.exit_gate_open;
    o.den  = bif.entry_denied;
    o.err  = bif.exit_error;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("cap=%h free=%0d full=%0d eg=%0d xg=%0d den=%0d err=%0d",
                     o.cap, o.free, o.full, o.eg, o.xg, o.den, o.err);
  endfunction

  task automatic check(input string name, input string got, input string exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got [%s] expected [%s]", name, got, exp);
    end
  endtask

  function automatic row_t mk(input logic e, input int pn, input logic x, input int xn,
                              input logic [7:0] cap, input int eg, input int xg,
                              input int den, input int err);
    row_t r;
    r.e = e; r.pn = 3'(pn); r.x = x; r.xn = 3'(xn);
    r.cap = cap; r.eg = eg; r.xg = xg; r.den = den; r.err = err;
    return r;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.cap  = m_cap;
    o.free = 4'(8 - $countones(m_cap));
    o.full = (m_cap == 8'hFF);
    o.eg   = (m_el > 0);
    o.xg   = (m_xl > 0);
    o.den  = m_den;
    o.err  = m_err;
    return o;
  endfunction

  // One clock: advance the model on the edge, queue the expectation, compare after it
  task automatic step();
    logic e_rise, x_rise, e_ok, x_ok;
    logic [7:0] nc;
    obs_t got, exp;
    @(posedge clk);
    if (reset) begin
      m_cap = '0; m_eq = 1'b0; m_xq = 1'b0;
      m_el = 0; m_xl = 0; m_den = 1'b0; m_err = 1'b0;
    end else begin
      e_rise = bif.entry & ~m_eq;
      x_rise = bif.exit & ~m_xq;
      e_ok = (m_el == 0) && e_rise && (m_cap != 8'hFF) && !m_cap[bif.park_number];
      x_ok = (m_xl == 0) && x_rise && m_cap[bif.exit_number];
      m_den = (m_el == 0) && e_rise && !e_ok;
      m_err = (m_xl == 0) && x_rise && !x_ok;
      nc = m_cap;
      if (e_ok) nc[bif.park_number] = 1'b1;
      if (x_ok) nc[bif.exit_number] = 1'b0;
      m_cap = nc;
      m_el = e_ok ? 4 : ((m_el > 0) ? m_el - 1 : 0);
      m_xl = x_ok ? 4 : ((m_xl > 0) ? m_xl - 1 : 0);
      m_eq = bif.entry;
      m_xq = bif.exit;
    end
    exp_q.push_back(model_obs());
    #1;
    got = observe();
    exp = exp_q.pop_front();
    check("cycle", fmt(got), fmt(exp));
    eg_cnt  += int'(got.eg);
    xg_cnt  += int'(got.xg);
    den_cnt += int'(got.den);
    err_cnt += int'(got.err);
  endtask

  task automatic clear_counts();
    eg_cnt = 0; xg_cnt = 0; den_cnt = 0; err_cnt = 0;
  endtask

  task automatic check_summary(input string name, input logic [7:0] cap, input int eg,
                               input int xg, input int den, input int err);
    string got, exp;
    got = $sformatf("cap=%h free=%0d full=%0d eg=%0d xg=%0d den=%0d err=%0d",
                    bif.parking_capacity, bif.free_count, bif.full,
                    eg_cnt, xg_cnt, den_cnt, err_cnt);
    exp = $sformatf("cap=%h free=%0d full=%0d eg=%0d xg=%0d den=%0d err=%0d",
                    cap, 8 - $countones(cap), (cap == 8'hFF), eg, xg, den, err);
    check(name, got, exp);
  endtask

  initial begin
    obs_t rst_exp;
    reset = 1'b1;
    bif.entry = 1'b0; bif.park_number = '0;
    bif.exit = 1'b0;  bif.exit_number = '0;
    rst_exp = '{cap: 8'h00, free: 4'd8, full: 1'b0, eg: 1'b0, xg: 1'b0, den: 1'b0, err: 1'b0};

    // Fill, refuse at full, exits, simultaneous and same-index events
    for (int i = 0; i < 8; i++) rows.push_back(mk(1, i, 0, 0, 8'((1 << (i + 1)) - 1), 4, 0, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 8'hFF, 0, 0, 1, 0));
    rows.push_back(mk(0, 0, 1, 3, 8'hF7, 0, 4, 0, 0));
    rows.push_back(mk(0, 0, 1, 3, 8'hF7, 0, 0, 0, 1));
    rows.push_back(mk(1, 3, 0, 0, 8'hFF, 4, 0, 0, 0));
    rows.push_back(mk(1, 3, 1, 3, 8'hF7, 0, 4, 1, 0));
    rows.push_back(mk(0, 0, 1, 0, 8'hF6, 0, 4, 0, 0));
    rows.push_back(mk(0, 0, 1, 1, 8'hF4, 0, 4, 0, 0));
    rows.push_back(mk(0, 0, 1, 2, 8'hF0, 0, 4, 0, 0));
    rows.push_back(mk(0, 0, 1, 4, 8'hE0, 0, 4, 0, 0));
    rows.push_back(mk(0, 0, 1, 6, 8'hA0, 0, 4, 0, 0));
    rows.push_back(mk(0, 0, 1, 7, 8'h20, 0, 4, 0, 0));
    rows.push_back(mk(1, 2, 1, 5, 8'h04, 4, 4, 0, 0));
    rows.push_back(mk(1, 2, 1, 2, 8'h00, 0, 4, 1, 0));
    rows.push_back(mk(0, 0, 1, 2, 8'h00, 0, 0, 0, 1));

    #1;
    check("reset_async", fmt(observe()), fmt(rst_exp));
    step(); step();
    reset = 1'b0;

    for (int r = 0; r < rows.size(); r++) begin
      clear_counts();
      bif.entry = rows[r].e; bif.park_number = rows[r].pn;
      bif.exit  = rows[r].x; bif.exit_number = rows[r].xn;
      step();
      bif.entry = 1'b0; bif.exit = 1'b0;
      repeat (5) step();
      check_summary($sformatf("row%0d", r), rows[r].cap, rows[r].eg, rows[r].xg,
                    rows[r].den, rows[r].err);
    end

    // Entry held high for 20 cycles admits once
    clear_counts();
    bif.entry = 1'b1; bif.park_number = 3'd0;
    repeat (20) step();
    bif.entry = 1'b0;
    step();
    check_summary("held_entry", 8'h01, 4, 0, 0, 0);

    // Re-pulse while the entry gate is open is ignored
    clear_counts();
    bif.entry = 1'b1; bif.park_number = 3'd1;
    step();
    bif.entry = 1'b0;
    step();
    bif.entry = 1'b1; bif.park_number = 3'd2;
    step();
    bif.entry = 1'b0;
    repeat (5) step();
    check_summary("repulse_open", 8'h03, 4, 0, 0, 0);

    // Reset two cycles into an open gate acts without a clock
    bif.entry = 1'b1; bif.park_number = 3'd4;
    step();
    bif.entry = 1'b0;
    step();
    #1 reset = 1'b1;
    #1 check("reset_mid_gate", fmt(observe()), fmt(rst_exp));
    step(); step();
    reset = 1'b0;
    clear_counts();
    bif.entry = 1'b1; bif.park_number = 3'd6;
    step();
    bif.entry = 1'b0;
    repeat (5) step();
    check_summary("recover_entry", 8'h40, 4, 0, 0, 0);

    // Sensor held high across reset release counts as one arrival
    reset = 1'b1;
    step();
    bif.entry = 1'b1; bif.park_number = 3'd1;
    step();
    reset = 1'b0;
    clear_counts();
    repeat (6) step();
    bif.entry = 1'b0;
    check_summary("held_through_reset", 8'h02, 4, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
